// File: rtl/perturbation_stall_injector_pkg.sv
// Shared definitions for the request/grant stall injector: mode codes,
// channel FSM states and the LFSR step/seed helpers.
package perturbation_defines;

  localparam logic [31:0] STANDARD = 32'h0000_0001;
  localparam logic [31:0] RANDOM   = 32'h0000_0002;
  localparam logic [31:0] PC_TRIG  = 32'h0000_0003;
  localparam logic [31:0] FIXED    = 32'h0000_0004;

  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam logic [15:0] LFSR_FALLBACK = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2
  } stall_state_e;

  // One Galois shift: feedback taps are applied when the outgoing bit is set
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = {1'b0, v[15:1]};
    return v[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

  // Per-channel seed; an all-zero seed would lock the LFSR, so it is replaced
  function automatic logic [15:0] ch_seed(input logic [15:0] base, input int ch);
    logic [15:0] s;
    s = base ^ 16'(ch + 1);
    return (s == 16'h0000) ? LFSR_FALLBACK : s;
  endfunction

endpackage

// File: rtl/perturbation_stall_injector_if.sv
// Core-side and memory-side req/gnt handshake bundle for all channels.
interface perturbation_stall_injector_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] core_req;
  logic [NUM_CH-1:0] core_gnt;
  logic [NUM_CH-1:0] mem_req;
  logic [NUM_CH-1:0] mem_gnt;

  modport master (
    output core_req,
    output mem_gnt,
    input  core_gnt,
    input  mem_req
  );

  modport slave (
    input  core_req,
    input  mem_gnt,
    output core_gnt,
    output mem_req
  );
endinterface

// File: rtl/perturbation_stall_injector_lfsr.sv
// 16-bit Galois LFSR used as the per-channel random delay source.
module perturb_lfsr
  import perturbation_defines::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] state_r;

  // LFSR register: reloads the seed on reset, steps whenever enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= SEED;
    end else if (en_i) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state_o = state_r[OUT_W-1:0];

endmodule

// File: rtl/perturbation_stall_injector.sv
// Per-channel request stall injector between core OBI ports and the memory
// model, with selectable delay policy and saturating stall statistics.
module perturbation_stall_injector
  import perturbation_defines::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          DELAY_W   = 4,
  parameter int          PC_W      = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_CH-1:0][31:0]          mode_i,
  input  logic [NUM_CH-1:0][DELAY_W-1:0]   delay_max_i,
  input  logic [PC_W-1:0]                  pc_i,
  input  logic                             pc_valid_i,
  input  logic [PC_W-1:0]                  trig_pc_i,
  perturbation_stall_injector_if.slave     bus,
  input  logic                             clear_stats_i,
  output logic [NUM_CH-1:0][31:0]          stall_cnt_o,
  output logic [NUM_CH-1:0]                protocol_err_o
);

  localparam logic [DELAY_W-1:0] D_ZERO = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] D_ONE  = {{(DELAY_W-1){1'b0}}, 1'b1};

  logic pc_hit_s;

  assign pc_hit_s = pc_valid_i & (pc_i == trig_pc_i);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    logic [DELAY_W-1:0] lfsr_s;
    stall_state_e       state_r, state_s;
    logic [DELAY_W-1:0] cnt_r, cnt_s;
    logic [DELAY_W-1:0] delay_s;
    logic               armed_r, armed_s;
    logic               consume_s;
    logic               stall_inc_s;
    logic [31:0]        stall_r, stall_s;
    logic               perr_r, perr_s;
    logic               mem_req_s, core_gnt_s;

    perturb_lfsr #(
      .SEED  (ch_seed(LFSR_SEED, ch)),
      .OUT_W (DELAY_W)
    ) u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (1'b1),
      .state_o (lfsr_s)
    );

    // Delay candidate for a request arriving in IDLE under the current mode
    always_comb begin
      delay_s = D_ZERO;
      case (mode_i[ch])
        RANDOM:  delay_s = lfsr_s & delay_max_i[ch];
        PC_TRIG: delay_s = armed_r ? delay_max_i[ch] : D_ZERO;
        FIXED:   delay_s = delay_max_i[ch];
        default: delay_s = D_ZERO;
      endcase
    end

    // Channel FSM next state, countdown and handshake outputs
    always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      consume_s   = 1'b0;
      stall_inc_s = 1'b0;
      perr_s      = perr_r;
      mem_req_s   = 1'b0;
      core_gnt_s  = 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.core_req[ch]) begin
            consume_s = (mode_i[ch] == PC_TRIG) & armed_r;
            if (delay_s == D_ZERO) begin
              mem_req_s  = 1'b1;
              core_gnt_s = bus.mem_gnt[ch];
              state_s    = bus.mem_gnt[ch] ? IDLE : PASS;
            end else begin
              cnt_s   = delay_s;
              state_s = WAIT;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WAIT: begin
          stall_inc_s = 1'b1;
          if (!bus.core_req[ch]) begin
            // Core abandoned the request mid-stall: protocol violation
            cnt_s   = D_ZERO;
            perr_s  = 1'b1;
            state_s = IDLE;
          end else if (cnt_r == D_ONE) begin
            cnt_s   = D_ZERO;
            state_s = PASS;
          end else begin
            cnt_s   = cnt_r - D_ONE;
            state_s = WAIT;
          end
        end
        PASS: begin
          mem_req_s  = bus.core_req[ch];
          core_gnt_s = bus.mem_gnt[ch];
          if (bus.core_req[ch] && bus.mem_gnt[ch]) begin
            state_s = IDLE;
          end else begin
            state_s = PASS;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = D_ZERO;
        end
      endcase
    end

    // Arming: a new trigger outranks consumption in the same cycle
    always_comb begin
      armed_s = armed_r;
      if ((mode_i[ch] == PC_TRIG) && pc_hit_s) begin
        armed_s = 1'b1;
      end else if (consume_s) begin
        armed_s = 1'b0;
      end else begin
        armed_s = armed_r;
      end
    end

    // Saturating stall counter; clear outranks increment
    always_comb begin
      stall_s = stall_r;
      if (clear_stats_i) begin
        stall_s = 32'h0000_0000;
      end else if (stall_inc_s && (stall_r != 32'hFFFF_FFFF)) begin
        stall_s = stall_r + 32'd1;
      end else begin
        stall_s = stall_r;
      end
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_r <= IDLE;
        cnt_r   <= D_ZERO;
        armed_r <= 1'b0;
        stall_r <= 32'h0000_0000;
        perr_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        armed_r <= armed_s;
        stall_r <= stall_s;
        perr_r  <= perr_s;
      end
    end

    assign bus.mem_req[ch]    = mem_req_s;
    assign bus.core_gnt[ch]   = core_gnt_s;
    assign stall_cnt_o[ch]    = stall_r;
    assign protocol_err_o[ch] = perr_r;

  end

endmodule
